// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: fetch-stage controller with memory handshake, prefetch queue, redirect flush and decode back-pressure
//   clock/reset                 rising-edge clock, asynchronous active-high reset
//   mem_read/mem_addr           read request and address to instruction memory
//   mem_ready/mem_rdata         read completion and returned word
//   redirect/redirect_pc        flush the queue and refetch from redirect_pc
//   ir_ready                    decode can accept the queue head
//   ir_valid/ir_data/ir_pc      queue head presented to decode
//   ir_load                     head accepted this cycle (IR1 load / pop)
module fetch_queue_ctrl #(
  parameter int PC_W = 8,
  parameter int INSN_W = 16,
  parameter int PC_INC = 1,
  parameter int QDEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_read,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ready,
  input  logic [INSN_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              ir_ready,
  output logic              ir_valid,
  output logic [INSN_W-1:0] ir_data,
  output logic [PC_W-1:0]   ir_pc,
  output logic              ir_load
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] fetch_pc, drain_addr;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [INSN_W-1:0] q_data [QDEPTH];
  logic [PC_W-1:0] q_pc [QDEPTH];
  logic push, flush;
  always_comb begin
    state_nx = state;
    mem_read = state == DRAIN || (state == REQ && count != CW'(QDEPTH));
    mem_addr = state == DRAIN ? drain_addr : fetch_pc;
    // the response of a request abandoned by redirect must still be consumed
    state_nx = state == IDLE ? REQ :
               state == REQ ? ((redirect && mem_read && !mem_ready) ? DRAIN : REQ) :
               (mem_ready ? REQ : DRAIN);
  end
  assign flush = redirect && state != IDLE;
  assign push = state == REQ && mem_read && mem_ready && !redirect;
  assign ir_valid = count != '0;
  assign ir_data = ir_valid ? q_data[rd_ptr] : '0;
  assign ir_pc = ir_valid ? q_pc[rd_ptr] : '0;
  assign ir_load = ir_valid && ir_ready;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      drain_addr <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (flush) begin
        fetch_pc <= redirect_pc;
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        if (state == REQ) drain_addr <= fetch_pc;
      end else begin
        if (push) begin
          q_data[wr_ptr] <= mem_rdata;
          q_pc[wr_ptr] <= fetch_pc;
          wr_ptr <= wr_ptr + PW'(1);
          fetch_pc <= fetch_pc + PC_W'(PC_INC);
        end
        if (ir_load) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(ir_load);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb_fetch_queue_ctrl: randomized and directed check of fetch_queue_ctrl against a queue-based model
module tb_fetch_queue_ctrl;
  localparam int QDEPTH = 2;
  logic clock = 0, reset = 1;
  logic mem_read, mem_ready = 0, redirect = 0, ir_ready = 0, ir_valid, ir_load;
  logic [7:0] mem_addr, redirect_pc = 0, ir_pc;
  logic [15:0] mem_rdata = 0, ir_data;
  int n_chk = 0, n_err = 0;
  typedef struct {logic [15:0] d; logic [7:0] pc;} ent_t;
  ent_t q[$];
  bit m_idle, m_drain;
  logic [7:0] m_fpc, m_daddr;

  fetch_queue_ctrl dut (.clock(clock), .reset(reset), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_ready(ir_ready), .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_load(ir_load));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idle = 1;
    m_drain = 0;
    m_fpc = 0;
    m_daddr = 0;
  endtask

  function automatic bit exp_read();
    return m_idle ? 0 : m_drain ? 1 : q.size() < QDEPTH;
  endfunction

  task automatic step(input logic rdy, input logic redir, input logic [7:0] rpc, input logic irr);
    bit rd, pop;
    mem_ready = rdy;
    redirect = redir;
    redirect_pc = rpc;
    ir_ready = irr;
    mem_rdata = 16'($urandom);
    #1;
    rd = exp_read();
    pop = q.size() != 0 && irr;
    chk("mem_read", mem_read, rd);
    if (rd) chk("mem_addr", mem_addr, m_drain ? m_daddr : m_fpc);
    chk("ir_valid", ir_valid, q.size() != 0);
    chk("ir_load", ir_load, pop);
    chk("ir_pc", ir_pc, q.size() != 0 ? q[0].pc : 8'h0);
    chk("ir_data", ir_data, q.size() != 0 ? q[0].d : 16'h0);
    @(posedge clock);
    if (m_idle) m_idle = 0;
    else if (redir) begin
      if (!m_drain && rd && !rdy) begin
        m_drain = 1;
        m_daddr = m_fpc;
      end else if (m_drain && rdy) m_drain = 0;
      q.delete();
      m_fpc = rpc;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_drain) begin
        if (rdy) m_drain = 0;
      end else if (rd && rdy) begin
        q.push_back('{mem_rdata, m_fpc});
        m_fpc = m_fpc + 8'd1;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_ir_valid", ir_valid, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    step(1, 0, 0, 1);
    chk("t1_read_c1", mem_read, 1);
    chk("t1_addr_c1", mem_addr, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1);
      chk("t1_ir_pc_seq", ir_pc, i);
      chk("t1_ir_load", ir_load, 1);
    end
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("t2_addr5", mem_addr, 5);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("t2_addr_hold", mem_addr, 5);
      chk("t2_read_hold", mem_read, 1);
    end
    step(1, 0, 0, 0);
    chk("t2_next_addr", mem_addr, 6);
    chk("t2_ir_pc", ir_pc, 5);
    step(1, 0, 0, 0);
    chk("t3_full_read", mem_read, 0);
    chk("t3_ir_pc", ir_pc, 5);
    step(1, 0, 0, 0);
    chk("t3_full_hold", mem_read, 0);
    step(1, 0, 0, 1);
    chk("t3_resume_read", mem_read, 1);
    chk("t3_resume_addr", mem_addr, 7);
    step(0, 1, 8'h40, 0);
    chk("t4_drain_addr", mem_addr, 7);
    chk("t4_flushed", ir_valid, 0);
    step(0, 0, 0, 1);
    chk("t4_drain_hold", mem_addr, 7);
    step(1, 0, 0, 1);
    chk("t4_new_addr", mem_addr, 8'h40);
    chk("t4_dropped", ir_valid, 0);
    step(1, 0, 0, 1);
    chk("t4_first_pc", ir_pc, 8'h40);
    step(1, 1, 8'h20, 1);
    chk("t5_flush", ir_valid, 0);
    chk("t5_addr", mem_addr, 8'h20);
    step(1, 1, 8'hFF, 1);
    chk("t6_addr_ff", mem_addr, 8'hFF);
    step(1, 0, 0, 1);
    chk("t6_ir_pc_ff", ir_pc, 8'hFF);
    chk("t6_wrap_addr", mem_addr, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 9) < 6);
    step(0, 1, 8'h10, 1);
    chk("rst_pre_read", mem_read, 1);
    reset = 1;
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_data", ir_data, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_ir_load", ir_load, 0);
    model_reset();
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 9) < 6);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
